// File: rtl/saturn_bus_arbiter.sv
// saturn_bus_arbiter: nibble-bus controller arbitrating instruction fetch and
// multi-nibble ALU data transfers, one beat per core cycle on the send/recv
// phase strobes. Optional build macro SATURN_BUS_WPROT_EN suppresses stores
// below ROM_TOP and pulses o_bus_error for each suppressed beat instead.
module saturn_bus_arbiter #(
  parameter int unsigned       ADDR_W  = 20,
  parameter logic [ADDR_W-1:0] ROM_TOP = ADDR_W'(20'h80000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en_bus_send,
  input  logic              i_en_bus_recv,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_valid,
  input  logic              i_data_req,
  input  logic              i_data_we,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [3:0]        i_data_len,
  input  logic [3:0]        i_data_wnib,
  output logic              o_data_beat,
  output logic              o_data_done,
  output logic [3:0]        o_nibble,
  output logic              o_stall,
  output logic              o_bus_error,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [3:0]        o_mem_wdata,
  input  logic [3:0]        i_mem_rdata
);

  localparam int unsigned NIB_W = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NIB_W-1:0]  wdata_q, wdata_d;
  logic [NIB_W-1:0]  nibble_q, nibble_d;
  logic rd_q, rd_d;
  logic wr_q, wr_d;
  logic we_q, we_d;
  logic out_q, out_d;     // a beat is issued and awaits its recv edge
  logic supp_q, supp_d;   // the outstanding beat is a suppressed store
  logic stall_q, stall_d;
  logic fval_q, fval_d;
  logic beat_q, beat_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic issue_beat;

  // Beat parameters: the grant edge uses the request lines, later beats the latched copies
  logic [ADDR_W-1:0] beat_addr_c;
  logic              beat_we_c;
  logic              below_rom_c;
  logic              wp_block_c;

  assign beat_addr_c = (state_q == S_DATA) ? daddr_q : i_data_addr;
  assign beat_we_c   = (state_q == S_DATA) ? we_q : i_data_we;
  assign below_rom_c = (beat_addr_c < ROM_TOP);

`ifdef SATURN_BUS_WPROT_EN
  assign wp_block_c = below_rom_c;
`else
  logic unused_wprot_c;
  assign wp_block_c     = 1'b0;
  assign unused_wprot_c = below_rom_c;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: grant only on a send strobe in IDLE, data before fetch
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_en_bus_send) begin
          if (i_data_req)       state_d = S_DATA;
          else if (i_fetch_req) state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (out_q && i_en_bus_recv) state_d = S_IDLE;
      end
      S_DATA: begin
        if (out_q && i_en_bus_recv && (cnt_q == CNT_W'(0))) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: issue beats on send, retire them on recv
  always_comb begin
    mem_addr_d = mem_addr_q;
    daddr_d    = daddr_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    nibble_d   = nibble_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    we_d       = we_q;
    out_d      = out_q;
    supp_d     = supp_q;
    stall_d    = stall_q;
    fval_d     = 1'b0;
    beat_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    issue_beat = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_en_bus_send) begin
          if (i_data_req) begin
            daddr_d    = i_data_addr;
            cnt_d      = i_data_len;
            we_d       = i_data_we;
            stall_d    = 1'b1;
            issue_beat = 1'b1;
          end else if (i_fetch_req) begin
            mem_addr_d = i_fetch_addr;
            rd_d       = 1'b1;
            out_d      = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (out_q && i_en_bus_recv) begin
          rd_d     = 1'b0;
          out_d    = 1'b0;
          nibble_d = i_mem_rdata;
          fval_d   = 1'b1;
        end
      end
      S_DATA: begin
        if (out_q) begin
          if (i_en_bus_recv) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            out_d   = 1'b0;
            supp_d  = 1'b0;
            err_d   = supp_q;
            beat_d  = 1'b1;
            daddr_d = daddr_q + ADDR_W'(1);
            cnt_d   = cnt_q - CNT_W'(1);
            if (!we_q) nibble_d = i_mem_rdata;
            if (cnt_q == CNT_W'(0)) begin
              done_d  = 1'b1;
              stall_d = 1'b0;
            end
          end
        end else if (i_en_bus_send) begin
          issue_beat = 1'b1;
        end
      end
      default: ;
    endcase

    if (issue_beat) begin
      mem_addr_d = beat_addr_c;
      out_d      = 1'b1;
      if (beat_we_c) begin
        wdata_d = i_data_wnib;
        wr_d    = !wp_block_c;
        supp_d  = wp_block_c;
      end else begin
        rd_d = 1'b1;
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr_q <= '0;
      daddr_q    <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      nibble_q   <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      we_q       <= 1'b0;
      out_q      <= 1'b0;
      supp_q     <= 1'b0;
      stall_q    <= 1'b0;
      fval_q     <= 1'b0;
      beat_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      daddr_q    <= daddr_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      nibble_q   <= nibble_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      we_q       <= we_d;
      out_q      <= out_d;
      supp_q     <= supp_d;
      stall_q    <= stall_d;
      fval_q     <= fval_d;
      beat_q     <= beat_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_mem_addr    = mem_addr_q;
  assign o_mem_rd      = rd_q;
  assign o_mem_wr      = wr_q;
  assign o_mem_wdata   = wdata_q;
  assign o_nibble      = nibble_q;
  assign o_stall       = stall_q;
  assign o_fetch_valid = fval_q;
  assign o_data_beat   = beat_q;
  assign o_data_done   = done_q;
  assign o_bus_error   = err_q;

endmodule

// File: tb/tb_saturn_bus_arbiter.sv
// Testbench for saturn_bus_arbiter: directed scenarios plus randomized core
// cycles, checked against a transaction-level model of the bus schedule.
module tb_saturn_bus_arbiter;

  localparam int unsigned       ADDR_W  = 20;
  localparam logic [ADDR_W-1:0] ROM_TOP = 20'h80000;
`ifdef SATURN_BUS_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  typedef enum int {OP_NONE, OP_FETCH, OP_LOAD, OP_STORE} op_e;

  logic clk = 1'b0;
  logic reset;
  logic en_send, en_recv;
  logic fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic fetch_valid;
  logic data_req, data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [3:0] data_len, data_wnib;
  logic data_beat, data_done;
  logic [3:0] nibble;
  logic stall, bus_error;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_rd, mem_wr;
  logic [3:0] mem_wdata, mem_rdata;

  saturn_bus_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .i_en_bus_send(en_send),
    .i_en_bus_recv(en_recv),
    .i_fetch_req  (fetch_req),
    .i_fetch_addr (fetch_addr),
    .o_fetch_valid(fetch_valid),
    .i_data_req   (data_req),
    .i_data_we    (data_we),
    .i_data_addr  (data_addr),
    .i_data_len   (data_len),
    .i_data_wnib  (data_wnib),
    .o_data_beat  (data_beat),
    .o_data_done  (data_done),
    .o_nibble     (nibble),
    .o_stall      (stall),
    .o_bus_error  (bus_error),
    .o_mem_addr   (mem_addr),
    .o_mem_rd     (mem_rd),
    .o_mem_wr     (mem_wr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model state
  bit                m_busy;
  logic [ADDR_W-1:0] m_addr;
  int                m_left;
  bit                m_we;
  logic [3:0]        m_nib;

  int rd_fix = -1;
  int stall_cycles = 0;
  int wr_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    case ($urandom_range(0, 2))
      0:       return 20'($urandom);
      1:       return 20'hFFFF0 | 20'($urandom_range(0, 15));
      default: return 20'h7FFF8 + 20'($urandom_range(0, 15));
    endcase
  endfunction

  // One core cycle: send clk, recv clk, two idle clks (idle recv strobes are strays)
  task automatic core_cycle();
    op_e               op;
    logic [ADDR_W-1:0] a;
    bit                blk, last, is_data;
    logic [3:0]        rd;
    a = '0;
    if (m_busy) begin
      op = m_we ? OP_STORE : OP_LOAD;
      a  = m_addr;
    end else if (data_req) begin
      m_busy = 1'b1;
      m_addr = data_addr;
      m_left = int'(data_len) + 1;
      m_we   = data_we;
      op     = data_we ? OP_STORE : OP_LOAD;
      a      = data_addr;
    end else if (fetch_req) begin
      op = OP_FETCH;
      a  = fetch_addr;
    end else begin
      op = OP_NONE;
    end
    is_data = (op == OP_LOAD) || (op == OP_STORE);
    blk     = (op == OP_STORE) && WPROT && (a < ROM_TOP);

    en_send = 1'b1;
    @(posedge clk); #1;
    en_send = 1'b0;
    check_eq("mem_rd", 32'(mem_rd), 32'((op == OP_LOAD) || (op == OP_FETCH)));
    check_eq("mem_wr", 32'(mem_wr), 32'((op == OP_STORE) && !blk));
    if (op != OP_NONE) check_eq("mem_addr", 32'(mem_addr), 32'(a));
    if ((op == OP_STORE) && !blk) check_eq("mem_wdata", 32'(mem_wdata), 32'(data_wnib));
    check_eq("stall_beat", 32'(stall), 32'(is_data));
    if (stall) stall_cycles++;
    if (mem_wr) wr_cnt++;

    rd        = (rd_fix >= 0) ? 4'(rd_fix) : 4'($urandom);
    mem_rdata = rd;
    en_recv   = 1'b1;
    @(posedge clk); #1;
    en_recv = 1'b0;
    last = is_data && (m_left == 1);
    if ((op == OP_LOAD) || (op == OP_FETCH)) m_nib = rd;
    if (is_data) begin
      m_addr = m_addr + 20'd1;
      m_left--;
      if (last) m_busy = 1'b0;
    end
    if (bus_error) err_cnt++;
    check_eq("fetch_valid", 32'(fetch_valid), 32'(op == OP_FETCH));
    check_eq("data_beat", 32'(data_beat), 32'(is_data));
    check_eq("data_done", 32'(data_done), 32'(last));
    check_eq("bus_error", 32'(bus_error), 32'(blk));
    check_eq("nibble", 32'(nibble), 32'(m_nib));
    check_eq("strobe_clr", 32'({mem_rd, mem_wr}), 32'(0));
    check_eq("stall_after", 32'(stall), 32'(m_busy));

    en_recv = ($urandom_range(0, 3) == 0);
    @(posedge clk); #1;
    en_recv = 1'b0;
    check_eq("quiet", 32'({fetch_valid, data_beat, data_done, bus_error, mem_rd, mem_wr}), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int clks);
    reset = 1'b0;
    for (int i = 0; i < clks; i++) begin
      @(posedge clk); #1;
      check_eq("rst_done", 32'(data_done), 32'(0));
    end
    check_eq("rst_addr", 32'(mem_addr), 32'(0));
    check_eq("rst_outs", 32'({fetch_valid, data_beat, data_done, nibble, stall,
                               bus_error, mem_rd, mem_wr, mem_wdata}), 32'(0));
    reset  = 1'b1;
    m_busy = 1'b0;
    m_nib  = 4'h0;
  endtask

  task automatic run_xfer(input bit we, input logic [ADDR_W-1:0] a, input logic [3:0] len, input bit drop);
    int i;
    i = 0;
    data_req  = 1'b1;
    data_we   = we;
    data_addr = a;
    data_len  = len;
    do begin
      data_wnib = 4'(3 + 4 * i);
      core_cycle();
      i++;
      if (drop) data_req = 1'b0;
    end while (m_busy && i < 20);
    data_req = 1'b0;
    check_eq("xfer_cycles", 32'(i), 32'(len) + 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en_send = 1'b0; en_recv = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_len = '0; data_wnib = '0;
    mem_rdata = '0;
    m_busy = 1'b0; m_addr = '0; m_left = 0; m_we = 1'b0; m_nib = '0;

    do_reset(2);

    // Single fetch
    fetch_req = 1'b1; fetch_addr = 20'h00100; rd_fix = 4'hA;
    core_cycle();
    fetch_req = 1'b0; rd_fix = -1;
    check_eq("fetch_nibble_hold", 32'(nibble), 32'hA);

    // Load len=4 at ROM_TOP while fetch is pending; fetch served right after
    fetch_req = 1'b1; fetch_addr = 20'h01234; stall_cycles = 0;
    run_xfer(1'b0, 20'h80000, 4'd4, 1'b0);
    check_eq("load_stall_cycles", 32'(stall_cycles), 32'd5);
    core_cycle();
    fetch_req = 1'b0;

    // Wrap at the top of the address space
    run_xfer(1'b0, 20'hFFFFE, 4'd3, 1'b0);
    check_eq("wrap_next_addr", 32'(m_addr), 32'h00002);

    // Store of two nibbles into the protected region
    wr_cnt = 0; err_cnt = 0;
    run_xfer(1'b1, 20'h00010, 4'd1, 1'b0);
    check_eq("store_wr_cnt", 32'(wr_cnt), WPROT ? 32'd0 : 32'd2);
    check_eq("store_err_cnt", 32'(err_cnt), WPROT ? 32'd2 : 32'd0);

    // Request dropped after the first beat still completes
    run_xfer(1'b0, 20'h23456, 4'd2, 1'b1);

    // Reset in the middle of a long transfer
    data_req = 1'b1; data_we = 1'b0; data_addr = 20'h40000; data_len = 4'd15;
    core_cycle();
    core_cycle();
    data_req = 1'b0;
    do_reset(3);
    core_cycle();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if (!m_busy) data_req = ($urandom_range(0, 3) == 0);
      else         data_req = 1'($urandom_range(0, 1));
      data_we    = 1'($urandom_range(0, 1));
      data_addr  = pick_addr();
      data_len   = 4'($urandom);
      data_wnib  = 4'($urandom);
      fetch_req  = 1'($urandom_range(0, 1));
      fetch_addr = 20'($urandom);
      core_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/saturn_bus_arbiter.md
# saturn_bus_arbiter

Nibble-bus controller between the Saturn core's phase generator and the memory port. It arbitrates the single nibble bus between the decoder's instruction fetch and the ALU's multi-nibble data transfers (D0/D1 loads and stores). It runs one nibble beat per core cycle, aligned to the bus-send and bus-receive phase strobes. While a data transfer owns the bus, it stalls the decoder.

## Interface
Parameters:
- ADDR_W, 20, nibble address width; all address arithmetic wraps mod 2^ADDR_W
- ROM_TOP, 20'h80000, first writable address; used only with write protection

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- i_en_bus_send  in  1  phase-0 strobe, one clk wide, once per core cycle
- i_en_bus_recv  in  1  phase-1 strobe, one clk wide, follows send by one clk
- i_fetch_req  in  1  decoder requests the nibble at i_fetch_addr
- i_fetch_addr  in  ADDR_W  fetch address (PC)
- o_fetch_valid  out  1  one-clk pulse; o_nibble holds the fetched nibble
- i_data_req  in  1  ALU transfer request; level, held until o_data_done
- i_data_we  in  1  1 = store, 0 = load
- i_data_addr  in  ADDR_W  start address
- i_data_len  in  4  nibble count minus 1 (0..15 gives 1..16 beats)
- i_data_wnib  in  4  store nibble; sampled on each send strobe of a store
- o_data_beat  out  1  one-clk pulse per completed beat
- o_data_done  out  1  one-clk pulse, coincident with the final beat
- o_nibble  out  4  last nibble read (fetch or load)
- o_stall  out  1  a data transfer owns the bus
- o_bus_error  out  1  one-clk pulse on a suppressed write (macro only; tied 0 otherwise)
- o_mem_addr  out  ADDR_W  memory address
- o_mem_rd  out  1  read strobe
- o_mem_wr  out  1  write strobe
- o_mem_wdata  out  4  write nibble
- i_mem_rdata  in  4  read nibble; valid at the recv edge

## Operation
- FSM states: IDLE, FETCH, DATA.
- **Arbitration:** happens only at a clk edge with i_en_bus_send=1 in IDLE. Data has priority over fetch. A losing fetch stays pending and receives no pulse.
- **IDLE → FETCH** (fetch granted):
  - latch o_mem_addr=i_fetch_addr and set o_mem_rd=1.
  - at the next recv edge: o_nibble=i_mem_rdata, o_fetch_valid pulses, o_mem_rd=0, state returns to IDLE.
- **IDLE → DATA** (data granted):
  - latch the address, the beat counter (=i_data_len) and the direction; set o_stall=1.
  - every send edge in DATA drives o_mem_addr to the current address. A load sets o_mem_rd; a store sets o_mem_wr with o_mem_wdata=i_data_wnib.
  - every recv edge: clear the strobes, pulse o_data_beat (loads also update o_nibble), increment the address with wrap, decrement the counter.
  - at the recv edge with counter=0: pulse o_data_done, clear o_stall, return to IDLE.
- Request lines are ignored outside the grant edge. Dropping i_data_req mid-transfer does not abort it.
- A recv strobe with nothing outstanding is a no-op. A send strobe while a strobe is outstanding is ignored.

## Timing
- Reset (reset=0 at a clk edge): state=IDLE and every output 0, including o_nibble and o_mem_addr. A transfer in progress is aborted silently with no done pulse.
- Latency: send edge → strobe high for exactly one clk → result pulse on the clk after the recv edge.
- A data transfer occupies i_data_len+1 consecutive core cycles. The earliest a pending fetch can be granted is the next send strobe after o_data_done.
- The requester must drop i_data_req within the 2 clks between o_data_done and the next send strobe; otherwise the transfer is re-granted.
- Address wrap: 2^ADDR_W−1 increments to 0 with no flag.

## Configuration
- SATURN_BUS_WPROT_EN defined: a store beat whose address is below ROM_TOP keeps o_mem_wr=0 and pulses o_bus_error at the recv edge. Beat, address and counter sequencing are unchanged, so o_data_done timing is identical.
- Undefined: all stores are issued and o_bus_error is constant 0.

## Test plan
- Reset held low for 3 clks mid-DATA → all outputs 0, state IDLE, no o_data_done pulse.
- Fetch at 20'h00100 with i_mem_rdata=4'hA → o_mem_addr=00100, o_mem_rd high for 1 clk, o_nibble=A, a single o_fetch_valid pulse.
- Load, len=4, from 20'h80000, with fetch also requested → 5 beats at 80000..80004; o_stall high for 5 core cycles; done on the 5th beat; fetch served in the following core cycle.
- Load, len=3, from 20'hFFFFE → addresses FFFFE, FFFFF, 00000, 00001.
- Store, len=1, to 20'h00010, nibbles 3,7 → with macro: no o_mem_wr, 2 o_bus_error pulses, done still issued. Without macro: two writes at 00010/00011 with data 3,7.
- i_data_req dropped after the first beat of a len=2 load → all 3 beats complete and done pulses.
